// File: rtl/inst_fetch.sv
// Instruction fetch front end: drives the synchronous-read instruction memory,
// tracks its one-cycle latency and presents {inst, pc, valid} to decode.
module inst_fetch #(
  parameter int unsigned       ADDR_W   = 10,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_dout,
  output logic [DATA_W-1:0] inst_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              inst_valid
);

  logic [ADDR_W-1:0] fetch_pc;
  logic              resp_valid;
  logic [ADDR_W-1:0] resp_pc;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              hold;

  // A stall only holds when there is something in F1 to hold; bubbles flow on.
  assign hold = stall && resp_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      resp_valid <= 1'b0;
      resp_pc    <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (redirect_valid) begin
      fetch_pc   <= redirect_pc;
      resp_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (hold) begin
      // Memory data for resp_pc is only present in the first stalled cycle;
      // afterwards the memory rereads fetch_pc, so capture once and keep it.
      if (!skid_valid) begin
        skid_data  <= imem_dout;
        skid_valid <= 1'b1;
      end
    end else if (fetch_en) begin
      resp_pc    <= fetch_pc;
      resp_valid <= 1'b1;
      skid_valid <= 1'b0;
      fetch_pc   <= fetch_pc + ADDR_W'(1);
    end else begin
      resp_valid <= 1'b0;
      skid_valid <= 1'b0;
    end
  end

  assign imem_addr  = fetch_pc;
  assign inst_valid = resp_valid;
  assign pc_out     = resp_pc;
  assign inst_out   = skid_valid ? skid_data : imem_dout;

endmodule
